// File: rtl/gpu_regs_pkg.sv
// gpu_regs_pkg: shared widths and reset-value rule for the GPU control register bank
package gpu_regs_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 20;
  function automatic logic [DATA_W-1:0] rst_val(input int i, input int rst_count);
    return (i < rst_count) ? DATA_W'(i + 1) : '0;
  endfunction
endpackage

// File: rtl/gpu_hw_ctrl_regbank.sv
// gpu_hw_ctrl_regbank: GPU control registers; GPU_REGS_SHADOW_EN adds a shadow bank committed on vsync_commit
module gpu_hw_ctrl_regbank
  import gpu_regs_pkg::*;
#(
  parameter int HW_REGS_SIZE = 8,
  parameter logic [ADDR_W-1:0] BASE_WRITE_ADDRESS = 20'h0,
  parameter int RST_COUNT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic re,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic vsync_commit,
  output logic [DATA_W-1:0] rd_data,
  output logic rd_valid,
  output logic commit_pending,
  output logic [DATA_W-1:0] GPU_HW_Control_regs [0:2**HW_REGS_SIZE-1]
);
  localparam int N = 2**HW_REGS_SIZE;
  logic hit;
  logic [HW_REGS_SIZE-1:0] idx;
  assign hit = addr_in[ADDR_W-1:HW_REGS_SIZE] == BASE_WRITE_ADDRESS[ADDR_W-1:HW_REGS_SIZE];
  assign idx = addr_in[HW_REGS_SIZE-1:0];
`ifdef GPU_REGS_SHADOW_EN
  logic [DATA_W-1:0] shadow [0:N-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= rst_val(i, RST_COUNT);
        GPU_HW_Control_regs[i] <= rst_val(i, RST_COUNT);
      end
      commit_pending <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      // commit copies pre-edge shadow, so a same-cycle write stays pending
      if (vsync_commit && commit_pending)
        for (int i = 0; i < N; i++) GPU_HW_Control_regs[i] <= shadow[i];
      if (we && hit) shadow[idx] <= data_in;
      commit_pending <= (we && hit) || (commit_pending && !vsync_commit);
      rd_valid <= re;
      rd_data <= (re && hit) ? shadow[idx] : '0;
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = vsync_commit;
  assign commit_pending = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) GPU_HW_Control_regs[i] <= rst_val(i, RST_COUNT);
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      if (we && hit) GPU_HW_Control_regs[idx] <= data_in;
      rd_valid <= re;
      rd_data <= (re && hit) ? GPU_HW_Control_regs[idx] : '0;
    end
  end
`endif
endmodule
